// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants for the RV32M multiply/divide sequencer
// Holds the funct3 opcode values, the 2-bit FSM state encodings and a
// constant-evaluable clog2 used to size the iteration counter.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - request/response bundle between exe stage and muldiv_seq
// master : exe stage side (drives start/op/a/b/flush, observes busy/stall/done/result)
// slave  : sequencer side
interface muldiv_seq_if #(parameter int WIDTH = 32) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, stall, done, result
    );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration of the shift-add / restoring-divide datapath
// Ports:
//   div_mode : 1 = restoring divide step, 0 = shift-add multiply step
//   hi, lo   : accumulator pair (product {hi,lo}, or remainder hi / dividend-quotient lo)
//   m        : multiplicand magnitude or divisor magnitude
//   hi_nxt, lo_nxt : accumulators after this iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    logic           ge;
    logic           unused_bits;

    always_comb begin
        // Multiply: conditionally add multiplicand, then shift {carry,hi,lo} right.
        sum   = {1'b0, hi} + {1'b0, m & {WIDTH{lo[0]}}};
        // Divide: shift next dividend bit into the partial remainder and try to subtract.
        trial = {hi, lo[WIDTH-1]};
        diff  = trial - {1'b0, m};
        ge    = (trial >= {1'b0, m});
        if (div_mode) begin
            // Remainder stays below the divisor, so the top bit is always zero here.
            hi_nxt = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], ge};
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end
    end

    assign unused_bits = diff[WIDTH] ^ trial[WIDTH];

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU sequencer
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : muldiv_seq_if.slave (start/op/a/b/flush in, busy/stall/done/result out)
// Flow: IDLE -> CALC (WIDTH iterations) -> FIX (sign/word select) -> DONE (done pulse).
// Divide-by-zero and signed overflow bypass CALC/FIX and go straight to DONE.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_seq_if.slave  bus
);

    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;
    logic             sa_q;
    logic             sb_q;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] result_q;

    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;

    logic             a_signed;
    logic             b_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             div_ovf;
    logic             accept;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   fix_result;

    // Operand signedness from funct3; unsigned operands never carry a sign.
    assign a_signed = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                      (bus.op == OP_DIV)  || (bus.op == OP_REM);
    assign b_signed = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
    assign a_neg    = a_signed & bus.a[WIDTH-1];
    assign b_neg    = b_signed & bus.b[WIDTH-1];
    assign a_mag    = a_neg ? (~bus.a + 1'b1) : bus.a;
    assign b_mag    = b_neg ? (~bus.b + 1'b1) : bus.b;

    assign div_zero = bus.op[2] && (bus.b == '0);
    assign div_ovf  = bus.op[2] && !bus.op[0] && (bus.a == SMIN) && (bus.b == {WIDTH{1'b1}});
    assign accept   = (state == ST_IDLE) && bus.start && !bus.flush;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (op_q[2]),
        .hi       (hi),
        .lo       (lo),
        .m        (m),
        .hi_nxt   (hi_nxt),
        .lo_nxt   (lo_nxt)
    );

    always_comb begin
        prod       = {hi, lo};
        prod_s     = (sa_q ^ sb_q) ? (~prod + 1'b1) : prod;
        quo_s      = (sa_q ^ sb_q) ? (~lo + 1'b1) : lo;
        rem_s      = sa_q ? (~hi + 1'b1) : hi;
        fix_result = '0;
        if (op_q[2]) begin
            fix_result = op_q[1] ? rem_s : quo_s;
        end else if (op_q[1:0] == 2'b00) begin
            fix_result = prod_s[WIDTH-1:0];
        end else begin
            fix_result = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            m        <= '0;
            result_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q <= bus.op;
                        sa_q <= a_neg;
                        sb_q <= b_neg;
                        cnt  <= '0;
                        hi   <= '0;
                        // Divide shifts the dividend out of lo; multiply shifts the multiplier out of lo.
                        lo   <= bus.op[2] ? a_mag : b_mag;
                        m    <= bus.op[2] ? b_mag : a_mag;
                        if (div_zero) begin
                            result_q <= bus.op[1] ? bus.a : {WIDTH{1'b1}};
                            state    <= ST_DONE;
                        end else if (div_ovf) begin
                            result_q <= bus.op[1] ? '0 : SMIN;
                            state    <= ST_DONE;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (bus.flush) begin
                        state <= ST_IDLE;
                    end else begin
                        hi  <= hi_nxt;
                        lo  <= lo_nxt;
                        cnt <= cnt + CW'(1);
                        if (cnt == CNT_LAST) state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (bus.flush) begin
                        state <= ST_IDLE;
                    end else begin
                        result_q <= fix_result;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = (state == ST_CALC) || (state == ST_FIX);
    assign bus.stall  = (bus.start && (state == ST_IDLE)) || bus.busy;
    assign bus.done   = (state == ST_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq
module tb_muldiv_seq;
    import muldiv_pkg::*;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] lat;
    } vec_t;

    localparam int NV = 19;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs [NV];

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start one op at cycle 0 and follow it until done (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res,
                          output logic stall_ok, output logic pulse_ok);
        lat      = -1;
        res      = 32'hDEADBEEF;
        stall_ok = 1'b1;
        pulse_ok = 1'b1;
        @(negedge clk);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        #1;
        if (!bus.stall) stall_ok = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.done) begin
                lat = c;
                res = bus.result;
                if (bus.stall) stall_ok = 1'b0;
                break;
            end
            if (!bus.stall) stall_ok = 1'b0;
        end
        @(negedge clk);
        #1;
        if (bus.done) pulse_ok = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic        stall_ok;
        logic        pulse_ok;
        logic        saw_done;
        logic [31:0] prev;

        checks = 0;
        errors = 0;

        vecs[0]  = '{OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 32'd34};
        vecs[1]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 32'd34};
        vecs[2]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd34};
        vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'd34};
        vecs[4]  = '{OP_DIVU,   32'd100,      32'd7,        32'd14,       32'd34};
        vecs[5]  = '{OP_REMU,   32'd100,      32'd7,        32'd2,        32'd34};
        vecs[6]  = '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'd34};
        vecs[7]  = '{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'd34};
        vecs[8]  = '{OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 32'd1};
        vecs[9]  = '{OP_REM,    32'd5,        32'd0,        32'd5,        32'd1};
        vecs[10] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd1};
        vecs[11] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'd1};
        vecs[12] = '{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 32'd1};
        vecs[13] = '{OP_REMU,   32'd7,        32'd0,        32'd7,        32'd1};
        vecs[14] = '{OP_MULHU,  32'h00010000, 32'h00010000, 32'h00000001, 32'd34};
        vecs[15] = '{OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'd34};
        vecs[16] = '{OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd34};
        vecs[17] = '{OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        32'd34};
        vecs[18] = '{OP_DIV,    32'd6,        32'hFFFFFFFF, 32'hFFFFFFFA, 32'd34};

        bus.start = 1'b0;
        bus.op    = OP_MUL;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset busy",   {31'd0, bus.busy},  32'd0);
        check("reset done",   {31'd0, bus.done},  32'd0);
        check("reset stall",  {31'd0, bus.stall}, 32'd0);
        check("reset result", bus.result,         32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, stall_ok, pulse_ok);
            check($sformatf("vec%0d result", i),  res,         vecs[i].res);
            check($sformatf("vec%0d latency", i), 32'(lat),    vecs[i].lat);
            check($sformatf("vec%0d stall", i),   {31'd0, stall_ok}, 32'd1);
            check($sformatf("vec%0d done width", i), {31'd0, pulse_ok}, 32'd1);
        end

        // Flush mid-CALC, then a fresh op.
        prev = vecs[NV-1].res;
        lat = -1;
        res = 32'hDEADBEEF;
        saw_done = 1'b0;
        @(negedge clk);
        bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd10; bus.start = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.flush = (c == 10);
            if (c == 12) begin
                bus.start = 1'b1;
                bus.a     = 32'd1000;
                bus.b     = 32'd7;
            end
            #1;
            if (c == 11) begin
                check("flush busy",   {31'd0, bus.busy}, 32'd0);
                check("flush result", bus.result,        prev);
            end
            if (bus.done) begin
                if (c < 12) saw_done = 1'b1;
                else begin
                    lat = c;
                    res = bus.result;
                    break;
                end
            end
        end
        check("flush no done",     {31'd0, saw_done}, 32'd0);
        check("after flush lat",   32'(lat),          32'd46);
        check("after flush result", res,              32'd142);

        // Start re-pulsed mid-operation is ignored.
        lat = -1;
        res = 32'hDEADBEEF;
        @(negedge clk);
        bus.op = OP_MUL; bus.a = 32'd7; bus.b = 32'hFFFFFFFD; bus.start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            bus.start = (c == 5);
            if (c == 5) begin
                bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
            end
            #1;
            if (bus.done) begin
                lat = c;
                res = bus.result;
                break;
            end
        end
        check("ignored start lat",    32'(lat), 32'd34);
        check("ignored start result", res,      32'hFFFFFFEB);
        @(negedge clk);
        #1;
        check("ignored start no 2nd op", {31'd0, bus.busy}, 32'd0);

        // Reset mid-operation.
        saw_done = 1'b0;
        @(negedge clk);
        bus.op = OP_MULHU; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF; bus.start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            rst = (c == 20);
            #1;
            if (c == 21) begin
                check("midrst busy",   {31'd0, bus.busy}, 32'd0);
                check("midrst done",   {31'd0, bus.done}, 32'd0);
                check("midrst result", bus.result,        32'd0);
            end
            if (bus.done) saw_done = 1'b1;
        end
        check("midrst no done", {31'd0, saw_done}, 32'd0);

        // Flush together with start in IDLE: start not accepted.
        @(negedge clk);
        bus.op = OP_DIV; bus.a = 32'd5; bus.b = 32'd0; bus.start = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        #1;
        check("flush+start done",   {31'd0, bus.done}, 32'd0);
        check("flush+start busy",   {31'd0, bus.busy}, 32'd0);
        check("flush+start result", bus.result,        32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
